// File: rtl/pipelined_adder_if.sv
// Operand and result handshake bundle for pipelined_adder.
// master drives operands and out_ready; slave is the adder itself.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES registered
// CHUNK-bit segments, with a valid/ready handshake and a global stall on output backpressure.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    logic stall;

    // Inputs seen by each segment adder: the beat for stage 0, stage k-1's registers otherwise.
    logic             src_valid [STAGES];
    logic [WIDTH-1:0] src_a     [STAGES];
    logic [WIDTH-1:0] src_bp    [STAGES];
    logic [WIDTH-1:0] src_psum  [STAGES];
    logic             src_carry [STAGES];

    logic [CHUNK:0]   seg       [STAGES];
    logic [WIDTH-1:0] psum_d    [STAGES];
    logic             carry_d   [STAGES];
    logic             ovf_d;

    logic             valid_q   [STAGES];
    logic [WIDTH-1:0] a_q       [STAGES];
    logic [WIDTH-1:0] bp_q      [STAGES];
    logic [WIDTH-1:0] psum_q    [STAGES];
    logic             carry_q   [STAGES];
    logic             ovf_q;

    assign stall = valid_q[LAST] & ~bus.out_ready;

    // Subtraction is A + ~B + 1, so cin is overridden rather than combined.
    assign src_valid[0] = bus.in_valid;
    assign src_a[0]     = bus.a;
    assign src_bp[0]    = bus.sub ? ~bus.b : bus.b;
    assign src_carry[0] = bus.sub | bus.cin;
    assign src_psum[0]  = '0;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign src_valid[k] = valid_q[k-1];
        assign src_a[k]     = a_q[k-1];
        assign src_bp[k]    = bp_q[k-1];
        assign src_carry[k] = carry_q[k-1];
        assign src_psum[k]  = psum_q[k-1];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, src_bp[k][k*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(src_carry[k]);
            psum_d[k] = src_psum[k];
            psum_d[k][k*CHUNK +: CHUNK] = seg[k][CHUNK-1:0];
            carry_d[k] = seg[k][CHUNK];
        end
    end

    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit position.
    assign ovf_d = src_a[LAST][WIDTH-1] ^ src_bp[LAST][WIDTH-1]
                 ^ psum_d[LAST][WIDTH-1] ^ carry_d[LAST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                bp_q[k]    <= '0;
                psum_q[k]  <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= src_valid[k];
                // Bubbles leave the data registers untouched.
                if (src_valid[k]) begin
                    a_q[k]     <= src_a[k];
                    bp_q[k]    <= src_bp[k];
                    psum_q[k]  <= psum_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
            if (src_valid[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = valid_q[LAST];
    assign bus.sum       = psum_q[LAST];
    assign bus.cout      = carry_q[LAST];
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit binary adder/subtractor with valid/ready handshakes on input and output. It generalises the 4-bit ripple-carry full-adder chain to any width. The carry chain is split into STAGES registered segments, so the block accepts one operation per cycle. It sits in the datapath test suite as the sequential counterpart to the combinational adders, for timing-driven synthesis and retiming experiments.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- STAGES, 4: number of pipeline segments; WIDTH % STAGES must equal 0; CHUNK = WIDTH/STAGES bits per segment.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; C0 = sub ? 1 : cin.
- Stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of A and B' plus the carry registered from stage k−1 (C0 for k=0).
- Stage k registers the following:
  - its partial sum bits;
  - its carry-out;
  - all partial sums from lower stages;
  - the unconsumed upper chunks of A and B'.
- Each stage has a valid bit. The last stage's registers drive sum, cout and out_valid.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Arithmetic is exactly modulo 2^WIDTH. Result is bit-identical to the combinational (WIDTH+1)-bit A+B'+C0.
- Stall = out_valid & ~out_ready. While stall=1, every stage register, including the valid bits, holds its value.
- in_ready = ~stall. A beat is accepted on a rising edge where in_valid & in_ready.
- When not stalled, each stage loads from its predecessor. Stage 0 loads the input beat, with valid = in_valid.
- Bubbles (invalid stages) propagate; they do not collapse during a stall. Throughput is 1 beat/cycle when out_ready=1.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- STAGES=1 degenerates to a single registered full-width adder.

## Timing
- Reset (async assert, synchronous release on the next clk edge) clears all stage valid bits, data registers, sum, cout and ovf to 0.
  - Therefore out_valid=0 and in_ready=1 while rst=1.
- Reset mid-operation discards every in-flight beat. No result from before reset ever appears after it.
- Latency: a beat accepted at edge t presents out_valid=1 with its result after edge t+STAGES−1, i.e. STAGES cycles, when no stall occurs. Each stalled cycle adds one cycle.
- Outputs change only on clk edges, or asynchronously to 0 on rst.
- in_ready is combinational from out_valid (register) and out_ready (input). No other combinational input-to-output path exists.
- A simultaneous accept and emit in the same cycle is legal and is the steady state.
- out_ready may toggle arbitrarily. sum, cout and ovf stay stable while out_valid=1 and out_ready=0.

## Test plan
- Reset with WIDTH=16, STAGES=4: assert rst mid-stream with 3 beats in flight. Required: outputs go to 0 immediately, in_ready=1, and no stale beat emerges over the next 10 cycles.
- Add carry ripple across all segments: a=0xFFFF, b=0x0001, cin=0, sub=0. Required: 4 cycles later sum=0x0000, cout=1, ovf=0.
  - Also a=0x7FFF, b=0x0001. Required: sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored). Required: sum=0xFFFE, cout=0, ovf=0.
  - Also a=0x8000, b=0x0001. Required: sum=0x7FFF, cout=1, ovf=1.
- Throughput: 20 back-to-back random beats with out_ready=1. Required: one result per cycle from cycle 4 on, every result matching the reference model.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1. Required:
  - in_ready=0 during the stall;
  - the held sum, cout and ovf stay constant;
  - no loss or duplication, with in-order output after release.
- Parameter sweep: (WIDTH, STAGES) = (8,1), (8,8), (32,4), (64,2) with 1000 random beats each, including sub and cin. Required: latency = STAGES and zero mismatches.
